// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv_2d column-stream feeder.
package conv_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int KNL_TAPS       = 9;
    localparam int KNL_COLS       = 3;
    localparam int FLUSH_CYCLES   = 4;
    localparam int FLUSH_W        = $clog2(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KNL,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Kernel taps are addressed 1..9 row-major; 0 and 10..15 are unused codes.
    function automatic logic knl_addr_ok(input logic [3:0] addr);
        return (addr >= 4'd1) && (addr <= 4'd9);
    endfunction

endpackage

// File: rtl/conv_frame_mem.sv
// Padded frame store: one synchronous write port, three combinational reads
// returning rows r, r+1, r+2 of the same column.
module conv_frame_mem #(
    parameter int IMAGE_HEIGHT = 3,
    parameter int IMAGE_WIDTH  = 12,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = $clog2(IMAGE_HEIGHT * IMAGE_WIDTH),
    parameter int ROW_W        = $clog2(IMAGE_HEIGHT),
    parameter int COL_W        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3
);

    localparam int DEPTH = IMAGE_HEIGHT * IMAGE_WIDTH;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] addr3;

    always_comb begin
        addr1 = ADDR_W'(int'(rd_row) * IMAGE_WIDTH + int'(rd_col));
        addr2 = ADDR_W'((int'(rd_row) + 1) * IMAGE_WIDTH + int'(rd_col));
        addr3 = ADDR_W'((int'(rd_row) + 2) * IMAGE_WIDTH + int'(rd_col));
    end

    // No reset: frame contents survive a reset and are reused by the next run.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = mem[addr1];
    assign rd_data2 = mem[addr2];
    assign rd_data3 = mem[addr3];

endmodule

// File: rtl/conv_stream_feeder.sv
// Drives conv_2d: three kernel columns, every 3-row window column by column,
// then a zero flush and a one-cycle done pulse.
module conv_stream_feeder
    import conv_pkg::*;
#(
    parameter int IMAGE_HEIGHT = 3,
    parameter int IMAGE_WIDTH  = 12,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = $clog2(IMAGE_HEIGHT * IMAGE_WIDTH)
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_knl_we,
    input  logic [3:0]        i_knl_addr,
    input  logic [DATA_W-1:0] i_knl_data,
    input  logic              i_start,
    input  logic              i_hold,
    output logic              o_load_knl,
    output logic              o_en_conv,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [DATA_W-1:0] o_data3,
    output logic              o_busy,
    output logic              o_done
);

    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(IMAGE_HEIGHT * IMAGE_WIDTH);

    state_t             state;
    logic [1:0]         knl_col;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [DATA_W-1:0]  taps     [KNL_TAPS];
    logic [DATA_W-1:0]  taps_eff [KNL_TAPS];

    logic               host_open;
    logic               frame_we;
    logic               knl_we_ok;
    logic               col_last;
    logic               stream_last;
    logic [ROW_W-1:0]   nxt_row;
    logic [COL_W-1:0]   nxt_col;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [1:0]         knl_sel;
    logic [3:0]         tap_base;
    logic [DATA_W-1:0]  mem_d1, mem_d2, mem_d3;
    logic [DATA_W-1:0]  knl_d1, knl_d2, knl_d3;

    // Host handshake: writes and i_start are single-cycle strobes acted on only
    // while IDLE; i_hold is a level sampled at every STREAM edge, no ready path.
    assign host_open = (state == ST_IDLE);
    assign frame_we  = host_open && i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L);
    assign knl_we_ok = host_open && i_knl_we && knl_addr_ok(i_knl_addr);

    // row/col name the column currently on the outputs; memory is read at the next one.
    assign col_last    = (col == COL_W'(IMAGE_WIDTH - 1));
    assign stream_last = col_last && (row == ROW_W'(IMAGE_HEIGHT - 3));
    assign nxt_col     = col_last ? '0 : col + 1'b1;
    assign nxt_row     = col_last ? row + 1'b1 : row;
    assign rd_row      = (state == ST_STREAM && !stream_last) ? nxt_row : '0;
    assign rd_col      = (state == ST_STREAM && !stream_last) ? nxt_col : '0;

    conv_frame_mem #(
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W)
    ) u_frame_mem (
        .clk     (clk),
        .wr_en   (frame_we),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data1(mem_d1),
        .rd_data2(mem_d2),
        .rd_data3(mem_d3)
    );

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int t = 0; t < KNL_TAPS; t++) begin
                taps[t] <= '0;
            end
        end else if (knl_we_ok) begin
            for (int t = 0; t < KNL_TAPS; t++) begin
                if (i_knl_addr == 4'(t + 1)) begin
                    taps[t] <= i_knl_data;
                end
            end
        end
    end

    // A tap written on the same edge as i_start must already show in column 0.
    always_comb begin
        for (int t = 0; t < KNL_TAPS; t++) begin
            taps_eff[t] = taps[t];
            if (knl_we_ok && (i_knl_addr == 4'(t + 1))) begin
                taps_eff[t] = i_knl_data;
            end
        end
    end

    assign knl_sel  = (state == ST_LOAD_KNL && knl_col != 2'(KNL_COLS - 1)) ? knl_col + 2'd1 : 2'd0;
    assign tap_base = {2'b00, knl_sel};
    assign knl_d1   = taps_eff[tap_base];
    assign knl_d2   = taps_eff[tap_base + 4'd3];
    assign knl_d3   = taps_eff[tap_base + 4'd6];

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= ST_IDLE;
            knl_col    <= '0;
            row        <= '0;
            col        <= '0;
            flush_cnt  <= '0;
            o_load_knl <= 1'b0;
            o_en_conv  <= 1'b0;
            o_data1    <= '0;
            o_data2    <= '0;
            o_data3    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_LOAD_KNL;
                        knl_col    <= '0;
                        o_load_knl <= 1'b1;
                        o_busy     <= 1'b1;
                        o_data1    <= knl_d1;
                        o_data2    <= knl_d2;
                        o_data3    <= knl_d3;
                    end
                end
                ST_LOAD_KNL: begin
                    if (knl_col == 2'(KNL_COLS - 1)) begin
                        state      <= ST_STREAM;
                        row        <= '0;
                        col        <= '0;
                        o_load_knl <= 1'b0;
                        o_en_conv  <= 1'b1;
                        o_data1    <= mem_d1;
                        o_data2    <= mem_d2;
                        o_data3    <= mem_d3;
                    end else begin
                        knl_col <= knl_col + 2'd1;
                        o_data1 <= knl_d1;
                        o_data2 <= knl_d2;
                        o_data3 <= knl_d3;
                    end
                end
                ST_STREAM: begin
                    if (i_hold) begin
                        o_en_conv <= 1'b0;
                    end else if (stream_last) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                        o_en_conv <= 1'b1;
                        o_data1   <= '0;
                        o_data2   <= '0;
                        o_data3   <= '0;
                    end else begin
                        row       <= nxt_row;
                        col       <= nxt_col;
                        o_en_conv <= 1'b1;
                        o_data1   <= mem_d1;
                        o_data2   <= mem_d2;
                        o_data3   <= mem_d3;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                        state     <= ST_DONE;
                        o_en_conv <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder: a 3x12 instance and a 5x4 instance.
module tb_conv_stream_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_wr_en = 0, a_knl_we = 0, a_start = 0, a_hold = 0;
    logic [5:0] a_wr_addr = 0;
    logic [7:0] a_wr_data = 0, a_knl_data = 0;
    logic [3:0] a_knl_addr = 0;
    logic       a_load, a_en, a_busy, a_done;
    logic [7:0] a_d1, a_d2, a_d3;

    logic       b_wr_en = 0, b_knl_we = 0, b_start = 0, b_hold = 0;
    logic [4:0] b_wr_addr = 0;
    logic [7:0] b_wr_data = 0, b_knl_data = 0;
    logic [3:0] b_knl_addr = 0;
    logic       b_load, b_en, b_busy, b_done;
    logic [7:0] b_d1, b_d2, b_d3;

    logic [7:0] mdl_frame_a [36];
    logic [7:0] mdl_frame_b [20];
    logic [7:0] mdl_knl_a [9];
    logic [7:0] mdl_knl_b [9];

    logic [27:0] exp_q [$];
    logic [27:0] got, exp_w;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_stream_feeder dut_a (
        .clk(clk), .i_nrst(rst_n),
        .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
        .i_knl_we(a_knl_we), .i_knl_addr(a_knl_addr), .i_knl_data(a_knl_data),
        .i_start(a_start), .i_hold(a_hold),
        .o_load_knl(a_load), .o_en_conv(a_en),
        .o_data1(a_d1), .o_data2(a_d2), .o_data3(a_d3),
        .o_busy(a_busy), .o_done(a_done)
    );

    conv_stream_feeder #(.IMAGE_HEIGHT(5), .IMAGE_WIDTH(4)) dut_b (
        .clk(clk), .i_nrst(rst_n),
        .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
        .i_knl_we(b_knl_we), .i_knl_addr(b_knl_addr), .i_knl_data(b_knl_data),
        .i_start(b_start), .i_hold(b_hold),
        .o_load_knl(b_load), .o_en_conv(b_en),
        .o_data1(b_d1), .o_data2(b_d2), .o_data3(b_d3),
        .o_busy(b_busy), .o_done(b_done)
    );

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic a_write(input logic [5:0] addr, input logic [7:0] data);
        a_wr_en = 1; a_wr_addr = addr; a_wr_data = data;
        @(negedge clk);
        a_wr_en = 0;
    endtask

    task automatic a_knl(input logic [3:0] addr, input logic [7:0] data);
        a_knl_we = 1; a_knl_addr = addr; a_knl_data = data;
        @(negedge clk);
        a_knl_we = 0;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [7:0] data);
        b_wr_en = 1; b_wr_addr = addr; b_wr_data = data;
        @(negedge clk);
        b_wr_en = 0;
    endtask

    task automatic b_knl(input logic [3:0] addr, input logic [7:0] data);
        b_knl_we = 1; b_knl_addr = addr; b_knl_data = data;
        @(negedge clk);
        b_knl_we = 0;
    endtask

    function automatic logic [7:0] frame_val(input bit inst_b, input int addr);
        return inst_b ? mdl_frame_b[addr] : mdl_frame_a[addr];
    endfunction

    function automatic logic [7:0] knl_val(input bit inst_b, input int idx);
        return inst_b ? mdl_knl_b[idx] : mdl_knl_a[idx];
    endfunction

    // Expected word: {load_knl, en_conv, done, busy, data1, data2, data3}.
    task automatic push_run(input bit inst_b, input int h, input int w,
                            input int hold_idx, input int hold_n);
        logic [7:0] v1, v2, v3;
        int s;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({4'b1001, knl_val(inst_b, k), knl_val(inst_b, 3 + k), knl_val(inst_b, 6 + k)});
        end
        s = 0;
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c < w; c++) begin
                v1 = frame_val(inst_b, r * w + c);
                v2 = frame_val(inst_b, (r + 1) * w + c);
                v3 = frame_val(inst_b, (r + 2) * w + c);
                exp_q.push_back({4'b0101, v1, v2, v3});
                if (s == hold_idx) begin
                    repeat (hold_n) exp_q.push_back({4'b0001, v1, v2, v3});
                end
                s++;
            end
        end
        repeat (4) exp_q.push_back({4'b0101, 24'h0});
        exp_q.push_back({4'b0010, 24'h0});
        exp_q.push_back(28'h0);
    endtask

    task automatic load_frame_a();
        for (int a = 0; a < 36; a++) begin
            mdl_frame_a[a] = 8'(a);
            a_write(6'(a), 8'(a));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int t = 0; t < 9; t++) begin
            mdl_knl_a[t] = 0;
            mdl_knl_b[t] = 0;
        end
        rst_n = 0;
        for (int i = 0; i < 6; i++) begin
            a_wr_en = 1'($urandom_range(0, 1)); a_wr_addr = 6'($urandom_range(0, 63));
            a_wr_data = 8'($urandom_range(0, 255)); a_knl_we = 1'($urandom_range(0, 1));
            a_knl_addr = 4'($urandom_range(0, 15)); a_knl_data = 8'($urandom_range(0, 255));
            a_start = 1'($urandom_range(0, 1)); a_hold = 1'($urandom_range(0, 1));
            b_start = 1;
            @(negedge clk);
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            vectors++;
            if (got !== 28'h0) begin
                miscompares++;
                $display("FAIL reset_a cyc=%0d got=%h exp=%h", i, got, 28'h0);
            end
            got = {b_load, b_en, b_done, b_busy, b_d1, b_d2, b_d3};
            vectors++;
            if (got !== 28'h0) begin
                miscompares++;
                $display("FAIL reset_b cyc=%0d got=%h exp=%h", i, got, 28'h0);
            end
        end
        a_wr_en = 0; a_knl_we = 0; a_start = 0; a_hold = 0; b_start = 0;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            vectors++;
            if (got !== 28'h0) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", i, got, 28'h0);
            end
        end
    endtask

    task automatic test_default_run();
        int n;
        load_frame_a();
        a_knl(4'd5, 8'h80);
        mdl_knl_a[4] = 8'h80;
        push_run(0, 3, 12, -1, 0);
        n = exp_q.size();
        a_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            a_start = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL default_run idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
        end
    endtask

    task automatic test_small_frame();
        int n;
        for (int a = 0; a < 20; a++) begin
            mdl_frame_b[a] = 8'(a);
            b_write(5'(a), 8'(a));
        end
        for (int t = 1; t <= 9; t++) begin
            mdl_knl_b[t - 1] = 8'(t);
            b_knl(4'(t), 8'(t));
        end
        push_run(1, 5, 4, -1, 0);
        n = exp_q.size();
        b_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            b_start = 0;
            got = {b_load, b_en, b_done, b_busy, b_d1, b_d2, b_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL small_frame idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        push_run(0, 3, 12, 5, 3);
        n = exp_q.size();
        a_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            a_start = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL hold idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
            a_hold = (idx >= 8 && idx < 11);
        end
        a_hold = 0;
    endtask

    task automatic test_protection();
        int n;
        push_run(0, 3, 12, -1, 0);
        n = exp_q.size();
        a_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            a_start = 0; a_wr_en = 0; a_knl_we = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL busy_protect idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
            if (idx == 5) begin
                a_wr_en = 1; a_wr_addr = 6'd0; a_wr_data = 8'h7F;
                a_knl_we = 1; a_knl_addr = 4'd2; a_knl_data = 8'h33;
                a_start = 1;
            end
        end
        a_write(6'd36, 8'h55);
        a_knl(4'd0, 8'h55);
        a_knl(4'd12, 8'h55);
        // Tap 1 written on the same edge as i_start must appear in column 0.
        mdl_knl_a[0] = 8'h11;
        push_run(0, 3, 12, -1, 0);
        n = exp_q.size();
        a_knl_we = 1; a_knl_addr = 4'd1; a_knl_data = 8'h11;
        a_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            a_start = 0; a_knl_we = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL rerun idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        push_run(0, 3, 12, -1, 0);
        a_start = 1;
        for (int idx = 0; idx < 7; idx++) begin
            @(negedge clk);
            a_start = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL pre_reset idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
        end
        #2 rst_n = 0;
        #1;
        got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
        vectors++;
        if (got !== 28'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", got, 28'h0);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int t = 0; t < 9; t++) mdl_knl_a[t] = 0;
        push_run(0, 3, 12, -1, 0);
        n = exp_q.size();
        a_start = 1;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            a_start = 0;
            got = {a_load, a_en, a_done, a_busy, a_d1, a_d2, a_d3};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL after_reset idx=%0d got=%h exp=%h", idx, got, exp_w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_default_run();
        test_small_frame();
        test_hold();
        test_protection();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
